lc_tx_sync_buf: RTL and testbench
=================================

Name: lc_tx_sync_buf

Overview:
- Double-flop synchronizer for a multi-bit life-cycle control word (default 4-bit lc_tx encoding).
- Feeds NumCopies separately buffered output copies; every output bit passes through its own don't-touch anchor buffer so synthesis cannot merge the copies.
- Sits at the receiving side of life-cycle control-signal propagation, one instance per consuming clock domain.

Parameters:
- Width, 4, bit width of the control word.
- NumCopies, 1, number of independently buffered output copies; must be >= 1.
- AsyncOn, 1, 1 = two synchronizer flop stages; 0 = combinational pass-through for a same-clock-domain sender.
- ResetValue, 4'b1010 (Off), value loaded into both sync stages on reset.
- OnValue, 4'b0101, valid "On" encoding; used only by the encoding checker.
- OffValue, 4'b1010, valid "Off" encoding; used only by the encoding checker.

Ports:
- clk_i  input  1  Clock; all state updates on the rising edge.
- rst_ni  input  1  Reset, synchronous, active-low.
- en_i  input  Width  Control word from the sending domain; may be asynchronous to clk_i.
- en_o  output  NumCopies*Width  Buffered copies; copy j is en_o[j*Width +: Width].
- err_o  output  1  Invalid-encoding flag; see Optional Feature.

Behaviour:
- AsyncOn=1:
  - Stage1 <= en_i and stage2 <= stage1 on each rising clk_i edge while rst_ni=1.
  - If rst_ni=0 at a rising edge, stage1 and stage2 both load ResetValue. No asynchronous reset path exists.
  - Latency: a value present at edge N appears on en_o after edge N+1 (2 clock edges). It is stable until the input change propagates.
  - Reset mid-operation: after the reset edge, en_o = ResetValue for every copy. After rst_ni returns to 1, the first post-reset sample appears after 2 further edges; en_o holds ResetValue until then.
- AsyncOn=0:
  - No flops in the data path; en_o copies equal en_i combinationally, with zero latency.
  - rst_ni has no effect on en_o.
  - clk_i and rst_ni are still consumed by a small unloaded dummy register so lint passes.
- Output buffering:
  - Every bit k of every copy j is driven through a dedicated buffer cell instance.
  - Total instance count is NumCopies*Width.
  - Each buffer is functionally a wire: out = in.
  - All copies are bit-identical every cycle.
- Encoding agnostic: any Width-bit pattern is synchronized unchanged; no recoding or filtering.
- Elaboration:
  - NumCopies < 1 is a fatal elaboration error.
  - ResetValue is truncated or extended to Width bits.
- Outputs are never X/Z once one reset edge has occurred (AsyncOn=1) or en_i is known (AsyncOn=0).

Optional Feature:
- Macro: LC_SYNC_ENC_CHECK_EN
- Defined:
  - err_o is a registered flag, updated each rising edge.
  - err_o <= 1 when the synchronized word (stage2; en_i if AsyncOn=0) equals neither OnValue nor OffValue; otherwise 0.
  - Synchronous reset clears err_o to 0.
  - err_o lags the corresponding en_o value by exactly 1 cycle.
- Not defined: err_o tied to 0 and no checker logic is generated.
- The macro has no effect on en_o in either case.

Test Plan:
- Reset: AsyncOn=1, NumCopies=3, hold rst_ni=0 for 2 edges with en_i=4'b0101 -> all three copies read 4'b1010. Release reset -> copies read 4'b0101 after the 2nd post-release edge, not before.
- Latency: steady state, en_i 4'b1010 -> 4'b0101 just before edge N -> en_o still 4'b1010 after edge N and 4'b0101 after edge N+1. A 1-cycle pulse on en_i appears as a 1-cycle pulse on en_o delayed by 2 edges.
- Reset mid-stream: with en_o=4'b0101, drive rst_ni=0 for one edge -> en_o=4'b1010 after that edge; it returns to en_i 2 edges after release.
- Bypass: AsyncOn=0, toggle en_i through 4'b0000, 4'b0101, 4'b1111 with rst_ni=0 and then 1 -> en_o follows each value in the same cycle regardless of rst_ni.
- Copies: NumCopies=4 with random en_i for 1000 cycles -> all four Width-bit slices are always equal, and each equals en_i delayed 2 cycles.
- Checker (LC_SYNC_ENC_CHECK_EN defined): synchronized word 4'b0011 -> err_o=1 one cycle after en_o shows 4'b0011. 4'b0101 and 4'b1010 -> err_o=0. With the macro undefined, err_o=0 always.

Source files
------------

// File: rtl/lc_tx_sync_buf.sv
// lc_tx_sync_buf: double-flop synchronizer for a multi-bit life-cycle control
// word. The synchronized word fans out to NumCopies output copies, and every
// output bit passes through its own anchor cell instance so the copies stay
// physically separate.
// Optional feature macro: LC_SYNC_ENC_CHECK_EN (registered invalid-encoding
// flag on err_o). When it is undefined, err_o is tied low.

// Anchor cell: functionally a wire. Each output bit gets its own instance.
module lc_tx_sync_buf_cell (
  input  logic in_i,
  output logic out_o
);
  assign out_o = in_i;
endmodule

module lc_tx_sync_buf #(
  parameter int               Width      = 4,
  parameter int               NumCopies  = 1,
  parameter bit               AsyncOn    = 1'b1,
  parameter logic [Width-1:0] ResetValue = 4'b1010,
  parameter logic [Width-1:0] OnValue    = 4'b0101,
  parameter logic [Width-1:0] OffValue   = 4'b1010
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Width-1:0]           en_i,
  output logic [NumCopies*Width-1:0] en_o,
  output logic                       err_o
);

  if (NumCopies < 1) begin : g_bad_copies
    $fatal(1, "lc_tx_sync_buf: NumCopies must be >= 1");
  end

  // The On and Off encodings must be distinguishable for the word to mean anything.
  if (OnValue == OffValue) begin : g_bad_encoding
    $fatal(1, "lc_tx_sync_buf: OnValue and OffValue must differ");
  end

  logic [Width-1:0] sync_word;

  if (AsyncOn) begin : g_sync
    logic [Width-1:0] stage1_q, stage1_d;
    logic [Width-1:0] stage2_q, stage2_d;

    // Next-state for the two synchronizer stages.
    always_comb begin
      stage1_d = en_i;
      stage2_d = stage1_q;
    end

    // Synchronizer flops; both stages load the reset value on a reset edge.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        stage1_q <= ResetValue;
        stage2_q <= ResetValue;
      end else begin
        stage1_q <= stage1_d;
        stage2_q <= stage2_d;
      end
    end

    assign sync_word = stage2_q;
  end else begin : g_bypass
    // Same-domain sender: no data flops. The unloaded register below keeps
    // clk_i and rst_ni consumed.
    logic dummy_q;

    // Dummy register with no fan-out.
    always_ff @(posedge clk_i) begin
      dummy_q <= rst_ni;
    end

    assign sync_word = en_i;
  end

  // One anchor cell per bit per copy, so synthesis cannot merge the copies.
  for (genvar j = 0; j < NumCopies; j++) begin : g_copy
    for (genvar k = 0; k < Width; k++) begin : g_bit
      lc_tx_sync_buf_cell u_cell (
        .in_i  (sync_word[k]),
        .out_o (en_o[j*Width + k])
      );
    end
  end

`ifdef LC_SYNC_ENC_CHECK_EN
  logic err_q, err_d;

  // Flag any synchronized word that is neither the On nor the Off encoding.
  always_comb begin
    err_d = (sync_word != OnValue) && (sync_word != OffValue);
  end

  // Registered flag: lags the corresponding en_o value by one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lc_tx_sync_buf.sv
// Testbench for lc_tx_sync_buf: a synchronized instance (4 copies) and a
// bypass instance (2 copies) share the same stimulus. Expected values come
// from a per-edge history of the applied inputs.
module tb_lc_tx_sync_buf;

  localparam int W = 4;
  localparam logic [W-1:0] RV  = 4'b1010;
  localparam logic [W-1:0] ONV = 4'b0101;
  localparam logic [W-1:0] OFV = 4'b1010;
  localparam int NA = 4;
  localparam int NB = 2;
  localparam int HMAX = 4096;

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     en;
  logic [NA*W-1:0]  en_o_a;
  logic [NB*W-1:0]  en_o_b;
  logic             err_a, err_b;

  int checks = 0;
  int errors = 0;

  // History of what was applied at each rising edge (index = edge number).
  logic [W-1:0] en_h  [0:HMAX-1];
  bit           rst_h [0:HMAX-1];
  int           edge_n = 0;

  lc_tx_sync_buf #(
    .Width(W), .NumCopies(NA), .AsyncOn(1'b1),
    .ResetValue(RV), .OnValue(ONV), .OffValue(OFV)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .en_o(en_o_a), .err_o(err_a)
  );

  lc_tx_sync_buf #(
    .Width(W), .NumCopies(NB), .AsyncOn(1'b0),
    .ResetValue(RV), .OnValue(ONV), .OffValue(OFV)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .en_o(en_o_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
    end
  endtask

  function automatic bit invalid(input logic [W-1:0] v);
    return (v != ONV) && (v != OFV);
  endfunction

  // Synchronized word after edge n: reset at edge n or n-1 yields the reset
  // value, otherwise the input applied one edge earlier.
  function automatic logic [W-1:0] exp_sync(input int n);
    if (!rst_h[n]) return RV;
    if (n < 2) return 'x;
    if (!rst_h[n-1]) return RV;
    return en_h[n-1];
  endfunction

  function automatic bit exp_err_a(input int n);
`ifdef LC_SYNC_ENC_CHECK_EN
    if (!rst_h[n] || n < 2) return 1'b0;
    return invalid(exp_sync(n-1));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_err_b(input int n);
`ifdef LC_SYNC_ENC_CHECK_EN
    if (!rst_h[n]) return 1'b0;
    return invalid(en_h[n]);
`else
    return 1'b0;
`endif
  endfunction

  // Apply one cycle of stimulus and check both instances.
  task automatic step(input logic [W-1:0] v, input logic r);
    @(negedge clk);
    en    = v;
    rst_n = r;
    #1;
    for (int j = 0; j < NB; j++) chk("bypass_comb", en_o_b[j*W +: W], v);
    @(posedge clk);
    edge_n++;
    en_h[edge_n]  = v;
    rst_h[edge_n] = r;
    #1;
    for (int j = 0; j < NA; j++) chk($sformatf("sync_copy%0d", j), en_o_a[j*W +: W], exp_sync(edge_n));
    for (int j = 0; j < NB; j++) chk("bypass_edge", en_o_b[j*W +: W], v);
    if (edge_n >= 2) chk("err_a", err_a, exp_err_a(edge_n));
    chk("err_b", err_b, exp_err_b(edge_n));
  endtask

  initial begin
    logic [W-1:0] v;
    en    = 4'b0101;
    rst_n = 1'b0;

    // Reset held for two edges with On applied, then released.
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b1);
    chk("reset_hold_after_1st_release_edge", en_o_a[W-1:0], RV);
    step(4'b0101, 1'b1);
    chk("first_sample_after_2nd_edge", en_o_a[W-1:0], 4'b0101);

    // Steady Off, then switch to On: two-edge latency.
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);
    step(4'b0101, 1'b1);
    chk("latency_edge_N", en_o_a[W-1:0], 4'b1010);
    step(4'b0101, 1'b1);
    chk("latency_edge_N1", en_o_a[W-1:0], 4'b0101);

    // One-cycle pulse, then invalid word for the checker.
    step(4'b0011, 1'b1);
    step(4'b0101, 1'b1);
    step(4'b0101, 1'b1);
    step(4'b0101, 1'b1);

    // Mid-stream reset for one edge.
    step(4'b0101, 1'b0);
    chk("midreset", en_o_a[W-1:0], RV);
    step(4'b0101, 1'b1);
    step(4'b0101, 1'b1);

    // Bypass patterns with reset low and high.
    step(4'b0000, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0101, 1'b1);
    step(4'b1111, 1'b1);

    // Randomized run, biased toward the valid encodings, occasional resets.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: v = ONV;
        1: v = OFV;
        default: v = W'($urandom);
      endcase
      step(v, ($urandom_range(0, 39) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
